// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// In-order instruction fetch: credit-limited memory requests, PC tag FIFO and a DEPTH-entry decode FIFO.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] pc
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic            started;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   kill;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW-1:0]   tag_wr, tag_rd;
    logic [XLEN-1:0] tag_mem   [DEPTH];
    logic [XLEN-1:0] fifo_pc   [DEPTH];
    logic [31:0]     fifo_inst [DEPTH];

    logic [CW:0]     credit;
    logic [XLEN-1:0] redirect_base;
    logic            req_fire;
    logic            rsp_drop;
    logic            rsp_keep;
    logic            head_valid;
    logic            push;
    logic            pop;

    assign imem_req_addr = fetch_pc;

    // Request credit, response classification and decode-side handshake.
    always_comb begin
        credit         = {1'b0, outstanding} + {1'b0, count};
        imem_req_valid = started && !redirect_valid && (credit < DEPTH_C);
        req_fire       = imem_req_valid && imem_req_ready;
        redirect_base  = redirect_pc & ~XLEN'(3);
        rsp_drop       = imem_rsp_valid && (kill != '0);
        rsp_keep       = imem_rsp_valid && (kill == '0) && !redirect_valid;
        head_valid     = (count != '0);
        push           = rsp_keep;
        inst_valid     = head_valid;
        inst           = head_valid ? fifo_inst[rd_ptr] : 32'h0;
        pc             = head_valid ? fifo_pc[rd_ptr] : '0;
`ifdef FETCH_BYPASS_EN
        if (!head_valid && rsp_keep) begin
            inst_valid = 1'b1;
            inst       = imem_rsp_data;
            pc         = tag_mem[tag_rd];
            push       = !inst_ready;
        end
`endif
        pop = head_valid && inst_ready && !redirect_valid;
    end

    // Control state: PC, counters and pointers; a redirect flushes everything still owed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            started     <= 1'b0;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            kill        <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
        end else begin
            started     <= 1'b1;
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                fetch_pc <= redirect_base;
                kill     <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                tag_wr   <= '0;
                tag_rd   <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                    tag_wr   <= tag_wr + PW'(1);
                end
                if (rsp_drop) kill   <= kill - CW'(1);
                if (rsp_keep) tag_rd <= tag_rd + PW'(1);
                if (push)     wr_ptr <= wr_ptr + PW'(1);
                if (pop)      rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage arrays; outputs are masked while empty so stale contents never show.
    always_ff @(posedge clk) begin
        if (req_fire) tag_mem[tag_wr] <= fetch_pc;
        if (push) begin
            fifo_pc[wr_ptr]   <= tag_mem[tag_rd];
            fifo_inst[wr_ptr] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// Directed bench for fetch_unit (default build): per-cycle vector table plus back-pressure,
// redirect, wrap-around and asynchronous-reset sequences against a fixed-latency memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;

    int checks   = 0;
    int failures = 0;

    int          lat;
    int          acc_cnt;
    logic        pv [4];
    logic [31:0] pa [4];

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic        erv;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl [11];

    fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .pc(pc)
    );

    always #5 clk = ~clk;

    // Memory: fixed latency, one response per accepted request, reset by the same rst.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        acc_cnt        = 0;
        for (int i = 0; i < 4; i++) begin
            pv[i] = 1'b0;
            pa[i] = 32'h0;
        end
        forever begin
            logic        macc;
            logic [31:0] maddr;
            @(negedge clk);
            macc  = imem_req_valid && imem_req_ready;
            maddr = imem_req_addr;
            if (macc) acc_cnt++;
            @(posedge clk);
            #1;
            if (!rst) begin
                for (int i = 0; i < 4; i++) pv[i] = 1'b0;
                acc_cnt = 0;
            end else begin
                for (int i = 3; i > 0; i--) begin
                    pv[i] = pv[i-1];
                    pa[i] = pa[i-1];
                end
                pv[0] = macc;
                pa[0] = maddr;
            end
            imem_rsp_valid = pv[lat-1];
            imem_rsp_data  = pa[lat-1] ^ 32'hA5A5_0000;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rp,
                                input logic ev, input logic [31:0] ep,
                                input logic erv, input logic [31:0] ea);
        vec_t v;
        v.rdy = r; v.redir = rd; v.rpc = rp;
        v.ev = ev; v.epc = ep; v.erv = erv; v.eaddr = ea;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l);
        tick();
        rst            = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        lat            = l;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Watch n consecutive deliveries (inst_ready held high) starting at first_pc.
    task automatic expect_stream(input logic [31:0] first_pc, input int n, input int budget,
                                 input string tag);
        int          got = 0;
        logic [31:0] exp = first_pc;
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge clk);
            if (inst_valid) begin
                chk($sformatf("%s pc%0d", tag, got), pc, exp);
                chk($sformatf("%s inst%0d", tag, got), inst, exp ^ 32'hA5A5_0000);
                exp = exp + 32'd4;
                got++;
            end
        end
        if (got < n) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: got %0d deliveries expected %0d", tag, got, n);
        end
    endtask

    initial begin
        rst            = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        lat            = 1;

        // Row k is the cycle after the (k+1)th edge past reset release; memory latency 1.
        tbl[0]  = mk(1, 0, 32'h0,   0, 32'h0,   1, 32'h0);
        tbl[1]  = mk(1, 0, 32'h0,   0, 32'h0,   1, 32'h4);
        tbl[2]  = mk(1, 0, 32'h0,   1, 32'h0,   1, 32'h8);
        tbl[3]  = mk(1, 0, 32'h0,   1, 32'h4,   1, 32'hC);
        tbl[4]  = mk(1, 0, 32'h0,   1, 32'h8,   1, 32'h10);
        tbl[5]  = mk(1, 0, 32'h0,   1, 32'hC,   1, 32'h14);
        tbl[6]  = mk(1, 1, 32'h103, 1, 32'h10,  0, 32'h18);
        tbl[7]  = mk(1, 0, 32'h0,   0, 32'h0,   1, 32'h100);
        tbl[8]  = mk(1, 0, 32'h0,   0, 32'h0,   1, 32'h104);
        tbl[9]  = mk(1, 0, 32'h0,   1, 32'h100, 1, 32'h108);
        tbl[10] = mk(1, 0, 32'h0,   1, 32'h104, 1, 32'h10C);

        repeat (2) @(negedge clk);
        chk("reset req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("reset req_addr", imem_req_addr, 32'h0);
        chk("reset inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("reset inst", inst, 32'h0);
        chk("reset pc", pc, 32'h0);
        tick();
        rst = 1'b1;

        // Stream from reset, then a redirect coinciding with a response and a decode pop.
        for (int i = 0; i < 11; i++) begin
            tick();
            inst_ready     = tbl[i].rdy;
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            @(negedge clk);
            chk($sformatf("row%0d req_valid", i), {31'h0, imem_req_valid}, {31'h0, tbl[i].erv});
            if (tbl[i].erv) chk($sformatf("row%0d req_addr", i), imem_req_addr, tbl[i].eaddr);
            chk($sformatf("row%0d inst_valid", i), {31'h0, inst_valid}, {31'h0, tbl[i].ev});
            if (tbl[i].ev) begin
                chk($sformatf("row%0d pc", i), pc, tbl[i].epc);
                chk($sformatf("row%0d inst", i), inst, tbl[i].epc ^ 32'hA5A5_0000);
            end
        end

        // Back-pressure: decode stalled, exactly DEPTH requests go out.
        do_reset(1);
        repeat (20) begin
            tick();
            @(negedge clk);
        end
        chk("bp req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("bp accepted", acc_cnt, 32'd4);
        chk("bp inst_valid", {31'h0, inst_valid}, 32'h1);
        tick();
        inst_ready = 1'b1;
        expect_stream(32'h0, 4, 20, "bp");

        // Redirect with two requests in flight at latency 3.
        do_reset(3);
        inst_ready = 1'b1;
        repeat (2) begin
            tick();
            @(negedge clk);
        end
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clk);
        chk("rd2 accepted", acc_cnt, 32'd2);
        chk("rd2 req_valid", {31'h0, imem_req_valid}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("rd2 next req_valid", {31'h0, imem_req_valid}, 32'h1);
        chk("rd2 next addr", imem_req_addr, 32'h100);
        chk("rd2 next inst_valid", {31'h0, inst_valid}, 32'h0);
        expect_stream(32'h100, 2, 30, "rd2");

        // Address wrap-around.
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("wrap addr", imem_req_addr, 32'hFFFF_FFFC);
        chk("wrap inst_valid", {31'h0, inst_valid}, 32'h0);
        expect_stream(32'hFFFF_FFFC, 2, 40, "wrap");

        // Asynchronous reset between edges with a full FIFO.
        do_reset(1);
        repeat (10) begin
            tick();
            @(negedge clk);
        end
        chk("ar full inst_valid", {31'h0, inst_valid}, 32'h1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("ar inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("ar req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("ar inst", inst, 32'h0);
        chk("ar pc", pc, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        chk("ar pre-start req_valid", {31'h0, imem_req_valid}, 32'h0);
        @(negedge clk);
        chk("ar restart req_valid", {31'h0, imem_req_valid}, 32'h1);
        chk("ar restart addr", imem_req_addr, 32'h0);
        expect_stream(32'h0, 3, 20, "ar");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
